tri_result_writer: RTL and testbench

//  Avalon-MM write master that stores fixed-size records of NDWORDS 32-bit words to SDRAM as
//  16-bit halfword writes; the write-side counterpart of the triangle reader. Sits between the
//  hit-result producer (tri_insector o_hit/o_t/o_tri_index) and the SDRAM controller, writing
//  one record per pixel/ray at baseaddr + index*NDWORDS*4.

---
 rtl/tri_result_writer.sv | 100 ++++++++++
 tb/tb_tri_result_writer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_result_writer.sv
// Avalon-MM write master: stores one NDWORDS-word record per request as consecutive
// 16-bit halfword writes at baseaddr + index*NDWORDS*4, low halfword first.
module tri_result_writer #(
    parameter int NDWORDS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             baseaddr,
    input  logic [31:0]             index,
    input  logic [32*NDWORDS-1:0]   data,
    input  logic                    write,
    output logic                    iready,
    output logic                    odone,
    output logic                    avm_m0_write,
    output logic [31:0]             avm_m0_address,
    output logic [15:0]             avm_m0_writedata,
    output logic [1:0]              avm_m0_byteenable,
    input  logic                    avm_m0_waitrequest
);

    localparam int NHALF = 2 * NDWORDS;
    localparam int HCW   = $clog2(NHALF) + 1;
    localparam logic [HCW-1:0] LAST_HW = HCW'(NHALF - 1);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [32*NDWORDS-1:0]   record_buf;
    logic [HCW-1:0]          hcnt;
    logic [HCW-1:0]          hnext;
    logic [31:0]             addr_reg;
    logic [15:0]             wdata_reg;
    logic [15:0]             next_half;
    logic                    odone_reg;
    logic                    accept;
    logic                    hw_done;
    logic                    last_hw;

    assign accept  = (state == IDLE) && write;
    assign hw_done = (state == WRITE) && !avm_m0_waitrequest;
    assign last_hw = (hcnt == LAST_HW);
    assign hnext   = hcnt + 1'b1;
    // Shifting (rather than part-selecting) keeps the past-the-end case at zero.
    assign next_half = 16'(record_buf >> (16 * hnext));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (write) state_next = WRITE;
            WRITE:   if (!avm_m0_waitrequest && last_hw) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            record_buf <= '0;
            hcnt       <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            odone_reg  <= 1'b0;
        end else begin
            odone_reg <= 1'b0;
            if (accept) begin
                record_buf <= data;
                addr_reg   <= baseaddr + index * 32'(NDWORDS * 4);
                wdata_reg  <= data[15:0];
                hcnt       <= '0;
            end else if (hw_done) begin
                if (last_hw) begin
                    odone_reg <= 1'b1;
                end else begin
                    hcnt      <= hnext;
                    addr_reg  <= addr_reg + 32'd2;
                    wdata_reg <= next_half;
                end
            end
        end
    end

    assign iready            = (state == IDLE);
    assign odone             = odone_reg;
    assign avm_m0_write      = (state == WRITE);
    assign avm_m0_address    = addr_reg;
    assign avm_m0_writedata  = wdata_reg;
    assign avm_m0_byteenable = 2'b11;

endmodule

// File: tb/tb_tri_result_writer.sv
// Directed and randomized checks for tri_result_writer with NDWORDS=3 against
// hand-computed halfword sequences and a slave memory model.
module tb_tri_result_writer;

    localparam int NDW = 3;
    localparam logic [32*NDW-1:0] REC_A = {32'd7, 32'h0001_8000, 32'd1};
    localparam logic [32*NDW-1:0] REC_B = {32'hCAFE_BABE, 32'h1234_5678, 32'hDEAD_BEEF};

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0]         baseaddr;
    logic [31:0]         index;
    logic [32*NDW-1:0]   data;
    logic                write;
    logic                iready;
    logic                odone;
    logic                avm_m0_write;
    logic [31:0]         avm_m0_address;
    logic [15:0]         avm_m0_writedata;
    logic [1:0]          avm_m0_byteenable;
    logic                avm_m0_waitrequest;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cycle;
    int be_errors = 0;

    logic [31:0] cap_addr[$];
    logic [15:0] cap_data[$];
    logic [31:0] seen_addr[$];
    logic [15:0] seen_data[$];

    logic [31:0] exp_a1[6] = '{32'h1018, 32'h101A, 32'h101C, 32'h101E, 32'h1020, 32'h1022};
    logic [15:0] exp_d1[6] = '{16'h0001, 16'h0000, 16'h8000, 16'h0001, 16'h0007, 16'h0000};
    logic [31:0] exp_a4[6] = '{32'hFFFF_FFF8, 32'hFFFF_FFFA, 32'hFFFF_FFFC, 32'hFFFF_FFFE,
                               32'h0000_0000, 32'h0000_0002};

    tri_result_writer #(.NDWORDS(NDW)) dut (
        .clk                (clk),
        .reset              (reset),
        .baseaddr           (baseaddr),
        .index              (index),
        .data               (data),
        .write              (write),
        .iready             (iready),
        .odone              (odone),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_address     (avm_m0_address),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_byteenable  (avm_m0_byteenable),
        .avm_m0_waitrequest (avm_m0_waitrequest)
    );

    always #5 clk = ~clk;

    // Presents one request once the writer is ready; returns one cycle after the accepting edge.
    task automatic send(input logic [31:0] b, input logic [31:0] i, input logic [32*NDW-1:0] d);
        int waited = 0;
        while (!iready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!iready) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL send_iready: iready=%b, required 1 within 50 cycles", iready);
        end
        baseaddr = b;
        index    = i;
        data     = d;
        write    = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    // Acts as the slave for one burst, collecting accepted halfwords until odone (cycle 1 = first burst cycle).
    task automatic capture(input int stall_hw, input int stall_len, input bit rand_stall, input int budget);
        int cyc  = 1;
        int left = stall_len;
        cap_addr.delete(); cap_data.delete();
        seen_addr.delete(); seen_data.delete();
        done_cycle = -1;
        while (cyc <= budget) begin
            if (odone) begin
                done_cycle = cyc;
                break;
            end
            avm_m0_waitrequest = 1'b0;
            if (avm_m0_write) begin
                seen_addr.push_back(avm_m0_address);
                seen_data.push_back(avm_m0_writedata);
                if (avm_m0_byteenable !== 2'b11) be_errors++;
                if (rand_stall) begin
                    avm_m0_waitrequest = 1'($urandom_range(0, 1));
                end else if (cap_addr.size() == stall_hw && left > 0) begin
                    avm_m0_waitrequest = 1'b1;
                    left--;
                end
                if (!avm_m0_waitrequest) begin
                    cap_addr.push_back(avm_m0_address);
                    cap_data.push_back(avm_m0_writedata);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        avm_m0_waitrequest = 1'b0;
        if (done_cycle < 0) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL capture_timeout: no odone within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (iready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_iready: got %b, required 1", iready); end
        n_checks++; if (odone !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_odone: got %b, required 0", odone); end
        n_checks++; if (avm_m0_write !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_write: got %b, required 0", avm_m0_write); end
        n_checks++; if (avm_m0_address !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_address: got %h, required 00000000", avm_m0_address); end
        n_checks++; if (avm_m0_writedata !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_writedata: got %h, required 0000", avm_m0_writedata); end
        n_checks++; if (avm_m0_byteenable !== 2'b11) begin n_fail++; $display("[TB] FAIL reset_byteenable: got %b, required 11", avm_m0_byteenable); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (iready !== 1'b1 || avm_m0_write !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_idle: iready=%b write=%b, required 1/0", iready, avm_m0_write); end
    endtask

    task automatic test_single();
        send(32'h1000, 32'd2, REC_A);
        capture(-1, 0, 1'b0, 50);
        n_checks++; if (cap_addr.size() != 6) begin n_fail++; $display("[TB] FAIL single_count: got %0d halfwords, required 6", cap_addr.size()); end
        for (int k = 0; k < 6 && k < cap_addr.size(); k++) begin
            n_checks++; if (cap_addr[k] !== exp_a1[k] || cap_data[k] !== exp_d1[k]) begin
                n_fail++; $display("[TB] FAIL single_hw%0d: got %h/%h, required %h/%h", k, cap_addr[k], cap_data[k], exp_a1[k], exp_d1[k]);
            end
        end
        n_checks++; if (done_cycle != 7) begin n_fail++; $display("[TB] FAIL single_odone_cycle: got %0d, required 7", done_cycle); end
        n_checks++; if (seen_addr.size() != 6) begin n_fail++; $display("[TB] FAIL single_write_cycles: got %0d, required 6", seen_addr.size()); end
        @(posedge clk); #1;
        n_checks++; if (odone !== 1'b0) begin n_fail++; $display("[TB] FAIL single_odone_width: got %b, required 0", odone); end
    endtask

    task automatic test_stall();
        send(32'h1000, 32'd2, REC_A);
        capture(2, 3, 1'b0, 50);
        n_checks++; if (cap_addr.size() != 6) begin n_fail++; $display("[TB] FAIL stall_count: got %0d halfwords, required 6", cap_addr.size()); end
        for (int k = 0; k < 6 && k < cap_addr.size(); k++) begin
            n_checks++; if (cap_addr[k] !== exp_a1[k] || cap_data[k] !== exp_d1[k]) begin
                n_fail++; $display("[TB] FAIL stall_hw%0d: got %h/%h, required %h/%h", k, cap_addr[k], cap_data[k], exp_a1[k], exp_d1[k]);
            end
        end
        n_checks++; if (done_cycle != 10) begin n_fail++; $display("[TB] FAIL stall_odone_cycle: got %0d, required 10", done_cycle); end
        n_checks++; if (seen_addr.size() != 9) begin n_fail++; $display("[TB] FAIL stall_write_cycles: got %0d, required 9", seen_addr.size()); end
        for (int k = 2; k <= 5 && k < seen_addr.size(); k++) begin
            n_checks++; if (seen_addr[k] !== 32'h101C || seen_data[k] !== 16'h8000) begin
                n_fail++; $display("[TB] FAIL stall_hold%0d: got %h/%h, required 0000101c/8000", k, seen_addr[k], seen_data[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 1;
        int odones = 0;
        int first_done = -1;
        int second_done = -1;
        cap_addr.delete(); cap_data.delete();
        baseaddr = 32'h0; index = 32'd0; data = REC_A; write = 1'b1;
        @(posedge clk); #1;
        index = 32'd1; data = REC_B;
        while (cyc <= 60 && odones < 2) begin
            if (odone) begin
                odones++;
                if (odones == 1) first_done = cyc; else second_done = cyc;
            end
            if (avm_m0_write) begin
                cap_addr.push_back(avm_m0_address);
                cap_data.push_back(avm_m0_writedata);
            end
            if (first_done >= 0 && cyc > first_done) write = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        write = 1'b0;
        n_checks++; if (cap_addr.size() != 12) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d writes, required 12", cap_addr.size()); end
        n_checks++; if (first_done != 7 || second_done != 14) begin n_fail++; $display("[TB] FAIL b2b_odone_cycles: got %0d/%0d, required 7/14", first_done, second_done); end
        if (cap_addr.size() >= 12) begin
            n_checks++; if (cap_addr[5] !== 32'h000A) begin n_fail++; $display("[TB] FAIL b2b_first_last: got %h, required 0000000a", cap_addr[5]); end
            n_checks++; if (cap_addr[6] !== 32'h000C || cap_data[6] !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL b2b_second_start: got %h/%h, required 0000000c/beef", cap_addr[6], cap_data[6]); end
            n_checks++; if (cap_addr[11] !== 32'h0016 || cap_data[11] !== 16'hCAFE) begin n_fail++; $display("[TB] FAIL b2b_second_end: got %h/%h, required 00000016/cafe", cap_addr[11], cap_data[11]); end
        end
    endtask

    task automatic test_wrap();
        send(32'hFFFF_FFF8, 32'd0, REC_A);
        capture(-1, 0, 1'b0, 50);
        n_checks++; if (cap_addr.size() != 6) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d halfwords, required 6", cap_addr.size()); end
        for (int k = 0; k < 6 && k < cap_addr.size(); k++) begin
            n_checks++; if (cap_addr[k] !== exp_a4[k]) begin
                n_fail++; $display("[TB] FAIL wrap_addr%0d: got %h, required %h", k, cap_addr[k], exp_a4[k]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int late_odone = 0;
        send(32'h3000, 32'd1, REC_A);
        avm_m0_waitrequest = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_checks++; if (avm_m0_write !== 1'b1 || avm_m0_address !== 32'h3010) begin n_fail++; $display("[TB] FAIL abort_pre: write=%b addr=%h, required 1/00003010", avm_m0_write, avm_m0_address); end
        reset = 1'b1;
        #1;
        n_checks++; if (avm_m0_write !== 1'b0 || odone !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_write_low: write=%b odone=%b, required 0/0", avm_m0_write, odone); end
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (iready !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_iready: got %b, required 1", iready); end
        repeat (3) begin
            @(posedge clk); #1;
            if (odone !== 1'b0 || avm_m0_write !== 1'b0) late_odone++;
        end
        n_checks++; if (late_odone != 0) begin n_fail++; $display("[TB] FAIL abort_quiet: %0d active cycles after reset, required 0", late_odone); end
        send(32'h3000, 32'd1, REC_B);
        capture(-1, 0, 1'b0, 50);
        n_checks++; if (cap_addr.size() != 6 || done_cycle != 7) begin n_fail++; $display("[TB] FAIL abort_restart_len: got %0d halfwords odone@%0d, required 6 odone@7", cap_addr.size(), done_cycle); end
        if (cap_addr.size() > 0) begin
            n_checks++; if (cap_addr[0] !== 32'h300C || cap_data[0] !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL abort_restart_first: got %h/%h, required 0000300c/beef", cap_addr[0], cap_data[0]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] ref_mem[logic [31:0]];
        logic [15:0] slave_mem[logic [31:0]];
        logic [32*NDW-1:0] d;
        logic [31:0] idx;
        logic [31:0] a;
        for (int r = 0; r < 8; r++) begin
            idx = 32'($urandom_range(0, 7));
            for (int w = 0; w < NDW; w++) d[32*w +: 32] = $urandom();
            send(32'h8000, idx, d);
            capture(-1, 0, 1'b1, 200);
            for (int k = 0; k < cap_addr.size(); k++) slave_mem[cap_addr[k]] = cap_data[k];
            for (int h = 0; h < 2*NDW; h++) ref_mem[32'h8000 + idx*12 + 32'(2*h)] = d[16*h +: 16];
        end
        n_checks++; if (slave_mem.size() != ref_mem.size()) begin n_fail++; $display("[TB] FAIL random_footprint: got %0d halfwords, required %0d", slave_mem.size(), ref_mem.size()); end
        if (ref_mem.first(a)) begin
            do begin
                n_checks++;
                if (!slave_mem.exists(a)) begin
                    n_fail++; $display("[TB] FAIL random_mem[%h]: got unwritten, required %h", a, ref_mem[a]);
                end else if (slave_mem[a] !== ref_mem[a]) begin
                    n_fail++; $display("[TB] FAIL random_mem[%h]: got %h, required %h", a, slave_mem[a], ref_mem[a]);
                end
            end while (ref_mem.next(a));
        end
        n_checks++; if (be_errors != 0) begin n_fail++; $display("[TB] FAIL byteenable: %0d write cycles without 11, required 0", be_errors); end
    endtask

    initial begin
        reset = 1'b1;
        write = 1'b0;
        baseaddr = '0;
        index = '0;
        data = '0;
        avm_m0_waitrequest = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
